// File: rtl/inst_encoder_loader_pkg.sv
// Shared constants for the RV32I instruction encoder/loader.
// Op-code map, RV32I opcode/funct fields, FSM state type, op classifiers.
package inst_encoder_loader_pkg;

    localparam logic [4:0] OP_BEQ   = 5'd0;
    localparam logic [4:0] OP_BNE   = 5'd1;
    localparam logic [4:0] OP_BLT   = 5'd2;
    localparam logic [4:0] OP_BGE   = 5'd3;
    localparam logic [4:0] OP_BLTU  = 5'd4;
    localparam logic [4:0] OP_BGEU  = 5'd5;
    localparam logic [4:0] OP_LW    = 5'd6;
    localparam logic [4:0] OP_SW    = 5'd7;
    localparam logic [4:0] OP_ADDI  = 5'd8;
    localparam logic [4:0] OP_SLTI  = 5'd9;
    localparam logic [4:0] OP_SLTIU = 5'd10;
    localparam logic [4:0] OP_XORI  = 5'd11;
    localparam logic [4:0] OP_ORI   = 5'd12;
    localparam logic [4:0] OP_ANDI  = 5'd13;
    localparam logic [4:0] OP_SLLI  = 5'd14;
    localparam logic [4:0] OP_SRLI  = 5'd15;
    localparam logic [4:0] OP_SRAI  = 5'd16;
    localparam logic [4:0] OP_ADD   = 5'd17;
    localparam logic [4:0] OP_SUB   = 5'd18;
    localparam logic [4:0] OP_SLL   = 5'd19;
    localparam logic [4:0] OP_SLT   = 5'd20;
    localparam logic [4:0] OP_SLTU  = 5'd21;
    localparam logic [4:0] OP_XOR   = 5'd22;
    localparam logic [4:0] OP_SRL   = 5'd23;
    localparam logic [4:0] OP_SRA   = 5'd24;
    localparam logic [4:0] OP_OR    = 5'd25;
    localparam logic [4:0] OP_AND   = 5'd26;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    function automatic logic is_branch(input logic [4:0] op);
        return op <= OP_BGEU;
    endfunction

    function automatic logic is_shift_imm(input logic [4:0] op);
        return (op >= OP_SLLI) && (op <= OP_SRAI);
    endfunction

endpackage

// File: rtl/inst_encoder_loader_encode.sv
// Combinational RV32I encoder for one descriptor.
// Ports: op_i/rd_i/rs1_i/rs2_i/imm_i in; word_o (32b), illegal_o out.
module rv32i_encode
    import inst_encoder_loader_pkg::*;
(
    input  logic [4:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [12:0] imm_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad_imm;

    always_comb begin
        f3 = 3'b000;
        unique case (op_i)
            OP_BEQ:   f3 = F3_BEQ;
            OP_BNE:   f3 = F3_BNE;
            OP_BLT:   f3 = F3_BLT;
            OP_BGE:   f3 = F3_BGE;
            OP_BLTU:  f3 = F3_BLTU;
            OP_BGEU:  f3 = F3_BGEU;
            OP_LW:    f3 = F3_WORD;
            OP_SW:    f3 = F3_WORD;
            OP_ADDI:  f3 = F3_ADD;
            OP_SLTI:  f3 = F3_SLT;
            OP_SLTIU: f3 = F3_SLTU;
            OP_XORI:  f3 = F3_XOR;
            OP_ORI:   f3 = F3_OR;
            OP_ANDI:  f3 = F3_AND;
            OP_SLLI:  f3 = F3_SLL;
            OP_SRLI:  f3 = F3_SR;
            OP_SRAI:  f3 = F3_SR;
            OP_ADD:   f3 = F3_ADD;
            OP_SUB:   f3 = F3_ADD;
            OP_SLL:   f3 = F3_SLL;
            OP_SLT:   f3 = F3_SLT;
            OP_SLTU:  f3 = F3_SLTU;
            OP_XOR:   f3 = F3_XOR;
            OP_SRL:   f3 = F3_SR;
            OP_SRA:   f3 = F3_SR;
            OP_OR:    f3 = F3_OR;
            OP_AND:   f3 = F3_AND;
            default:  f3 = 3'b000;
        endcase
    end

    always_comb begin
        f7 = F7_ZERO;
        if (op_i == OP_SUB || op_i == OP_SRA || op_i == OP_SRAI) begin
            f7 = F7_ALT;
        end
    end

    // Branch offsets must be even; other immediates must fit 12 signed
    // bits; shift-immediates carry only a 5-bit shamt.
    always_comb begin
        if (is_branch(op_i)) begin
            bad_imm = imm_i[0];
        end else begin
            bad_imm = imm_i[12] != imm_i[11];
        end
        if (is_shift_imm(op_i) && imm_i[11:5] != 7'd0) begin
            bad_imm = 1'b1;
        end
    end

    always_comb begin
        word_o    = 32'd0;
        illegal_o = bad_imm;
        unique case (1'b1)
            (op_i > OP_AND): begin
                illegal_o = 1'b1;
            end
            is_branch(op_i): begin
                word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3,
                          imm_i[4:1], imm_i[11], OPC_BRANCH};
            end
            (op_i == OP_LW): begin
                word_o = {imm_i[11:0], rs1_i, f3, rd_i, OPC_LOAD};
            end
            (op_i == OP_SW): begin
                word_o = {imm_i[11:5], rs2_i, rs1_i, f3,
                          imm_i[4:0], OPC_STORE};
            end
            is_shift_imm(op_i): begin
                word_o = {f7, imm_i[4:0], rs1_i, f3, rd_i, OPC_OPIMM};
            end
            (op_i >= OP_ADDI && op_i <= OP_ANDI): begin
                word_o = {imm_i[11:0], rs1_i, f3, rd_i, OPC_OPIMM};
            end
            (op_i >= OP_ADD && op_i <= OP_AND): begin
                word_o = {f7, rs2_i, rs1_i, f3, rd_i, OPC_OP};
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Streams descriptors into RV32I words and writes them to instr memory.
// Ports: start/base, descriptor valid/ready bundle, imem write, status.
module inst_encoder_loader
    import inst_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [4:0]        in_op_i,
    input  logic [4:0]        in_rd_i,
    input  logic [4:0]        in_rs1_i,
    input  logic [4:0]        in_rs2_i,
    input  logic [12:0]       in_imm_i,
    input  logic              in_last_i,
    output logic              imem_we_o,
    input  logic              imem_ready_i,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [7:0]        err_cnt_o,
    output logic [ADDR_W:0]   words_o
);

    state_e            state_q;
    logic              vld_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [7:0]        cnt_q;
    logic [ADDR_W:0]   words_q;
    logic              done_q;

    logic [31:0] enc_word;
    logic        enc_ill;
    logic        acc;
    logic        wfire;

    rv32i_encode u_enc (
        .op_i      (in_op_i),
        .rd_i      (in_rd_i),
        .rs1_i     (in_rs1_i),
        .rs2_i     (in_rs2_i),
        .imm_i     (in_imm_i),
        .word_o    (enc_word),
        .illegal_o (enc_ill)
    );

    // The single output slot may be refilled in the cycle it drains.
    assign in_ready_o = (state_q == S_RUN) & (~vld_q | imem_ready_i);
    assign acc        = in_valid_i & in_ready_o;
    assign wfire      = vld_q & imem_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            vld_q   <= 1'b0;
            wdata_q <= 32'd0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            words_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wfire) begin
                vld_q   <= 1'b0;
                addr_q  <= addr_q + ADDR_W'(1);
                words_q <= words_q + (ADDR_W+1)'(1);
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        addr_q  <= base_i;
                        err_q   <= 1'b0;
                        cnt_q   <= 8'd0;
                        words_q <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (acc) begin
                        if (enc_ill) begin
                            err_q <= 1'b1;
                            if (cnt_q != 8'hFF) begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end else begin
                            vld_q   <= 1'b1;
                            wdata_q <= enc_word;
                        end
                        if (in_last_i) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!vld_q || imem_ready_i) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_we_o    = vld_q;
    assign imem_addr_o  = addr_q;
    assign imem_wdata_o = wdata_q;
    assign busy_o       = state_q != S_IDLE;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign err_cnt_o    = cnt_q;
    assign words_o      = words_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed self-checking bench for inst_encoder_loader.
// Linear steps; inputs driven and outputs sampled on the falling edge.
module tb_inst_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  base;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op, in_rd, in_rs1, in_rs2;
    logic [12:0] in_imm;
    logic        in_last;
    logic        we;
    logic        mem_rdy;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        busy, done, err;
    logic [7:0]  err_cnt;
    logic [10:0] words;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    inst_encoder_loader #(.ADDR_W(10)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .base_i       (base),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_op_i      (in_op),
        .in_rd_i      (in_rd),
        .in_rs1_i     (in_rs1),
        .in_rs2_i     (in_rs2),
        .in_imm_i     (in_imm),
        .in_last_i    (in_last),
        .imem_we_o    (we),
        .imem_ready_i (mem_rdy),
        .imem_addr_o  (addr),
        .imem_wdata_o (wdata),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .err_cnt_o    (err_cnt),
        .words_o      (words)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            $display("FAIL %s: got %h want %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_rdy"},   {31'd0, in_ready}, 32'd0);
        chk({p, "_we"},    {31'd0, we},       32'd0);
        chk({p, "_busy"},  {31'd0, busy},     32'd0);
        chk({p, "_done"},  {31'd0, done},     32'd0);
        chk({p, "_err"},   {31'd0, err},      32'd0);
        chk({p, "_addr"},  {22'd0, addr},     32'd0);
        chk({p, "_wdata"}, wdata,             32'd0);
        chk({p, "_cnt"},   {24'd0, err_cnt},  32'd0);
        chk({p, "_words"}, {21'd0, words},    32'd0);
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [12:0] imm, input logic last);
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        in_last  = last;
    endtask

    task automatic start_load(input logic [9:0] b);
        start = 1'b1;
        base  = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_word(input string p, input logic [9:0] a,
                            input logic [31:0] d);
        chk({p, "_we"},   {31'd0, we}, 32'd1);
        chk({p, "_addr"}, {22'd0, addr}, {22'd0, a});
        chk({p, "_data"}, wdata, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base = '0; in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; in_last = 1'b0; mem_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // ADDI x1,x0,5 at 0x010
        start_load(10'h010);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        drive(5'd8, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
        #1 chk("t1_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_word("t1", 10'h010, 32'h00500093);
        @(negedge clk);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_words", {21'd0, words}, 32'd1);
        @(negedge clk);
        chk("t1_done_end", {31'd0, done}, 32'd0);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);

        // back-to-back ADD, SUB, SW; stray start ignored mid-load
        start_load(10'h020);
        start = 1'b1; base = 10'h300;
        drive(5'd17, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk_word("t2a", 10'h020, 32'h002081B3);
        drive(5'd18, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0);
        #1 chk("t2_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk_word("t2b", 10'h021, 32'h402081B3);
        drive(5'd7, 5'd0, 5'd1, 5'd2, 13'd8, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_word("t2c", 10'h022, 32'h0020A423);
        @(negedge clk);
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_words", {21'd0, words}, 32'd3);
        @(negedge clk);

        // LW x5,-4(x1) stalled 3 cycles, then BEQ x1,x2,+8
        mem_rdy = 1'b0;
        start_load(10'h030);
        drive(5'd6, 5'd5, 5'd1, 5'd0, 13'h1FFC, 1'b0);
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd1, 5'd2, 13'd8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_rdy", {31'd0, in_ready}, 32'd0);
            chk_word("t3_stall", 10'h030, 32'hFFC0A283);
            @(negedge clk);
        end
        mem_rdy = 1'b1;
        #1 chk("t3_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_word("t3b", 10'h031, 32'h00208463);
        @(negedge clk);
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_words", {21'd0, words}, 32'd2);
        @(negedge clk);

        // SRAI, then illegal SLLI/op30/odd branch, then ADDI
        start_load(10'h040);
        drive(5'd16, 5'd4, 5'd4, 5'd0, 13'd3, 1'b0);
        @(negedge clk);
        chk_word("t4a", 10'h040, 32'h40325213);
        drive(5'd14, 5'd1, 5'd1, 5'd0, 13'd32, 1'b0);
        @(negedge clk);
        chk("t4_slli_we", {31'd0, we}, 32'd0);
        chk("t4_slli_err", {31'd0, err}, 32'd1);
        chk("t4_slli_cnt", {24'd0, err_cnt}, 32'd1);
        drive(5'd30, 5'd1, 5'd1, 5'd1, 13'd0, 1'b0);
        @(negedge clk);
        chk("t4_op30_cnt", {24'd0, err_cnt}, 32'd2);
        drive(5'd1, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0);
        @(negedge clk);
        chk("t4_bodd_cnt", {24'd0, err_cnt}, 32'd3);
        chk("t4_bodd_we", {31'd0, we}, 32'd0);
        drive(5'd8, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_word("t4b", 10'h041, 32'h00500093);
        @(negedge clk);
        chk("t4_done", {31'd0, done}, 32'd1);
        chk("t4_words", {21'd0, words}, 32'd2);
        chk("t4_err_hold", {31'd0, err}, 32'd1);
        @(negedge clk);

        // address wrap from 0x3FF
        start_load(10'h3FF);
        chk("t5_err_clr", {31'd0, err}, 32'd0);
        chk("t5_cnt_clr", {24'd0, err_cnt}, 32'd0);
        chk("t5_words_clr", {21'd0, words}, 32'd0);
        drive(5'd8, 5'd1, 5'd0, 5'd0, 13'd5, 1'b0);
        @(negedge clk);
        chk_word("t5a", 10'h3FF, 32'h00500093);
        drive(5'd17, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_word("t5b", 10'h000, 32'h002081B3);
        @(negedge clk);
        chk("t5_done", {31'd0, done}, 32'd1);
        chk("t5_words", {21'd0, words}, 32'd2);
        @(negedge clk);

        // reset while stalled, then a clean load
        mem_rdy = 1'b0;
        start_load(10'h100);
        drive(5'd6, 5'd5, 5'd1, 5'd0, 13'h1FFC, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_word("t6_pend", 10'h100, 32'hFFC0A283);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset("t6_rst");
        @(negedge clk);
        rst_n = 1'b1;
        mem_rdy = 1'b1;
        @(negedge clk);
        start_load(10'h200);
        drive(5'd8, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk_word("t6_new", 10'h200, 32'h00500093);
        @(negedge clk);
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_words", {21'd0, words}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
